complex_to_magsq_avg: RTL and testbench

- Parametrised successor to the team's fixed-width magnitude-squared block.
- Computes I^2+Q^2 per complex AXI-Stream sample in an elastic three-stage pipeline, scales and saturates the result to a configurable output width, then optionally averages over 2^log_avg samples.
- Sits after DDC/FFT blocks in RFNoC computation chains for power and spectrum measurement.

---
 rtl/complex_to_magsq_avg.sv | 190 +++++++++++++++++++
 tb/tb_complex_to_magsq_avg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_to_magsq_avg.sv
// complex_to_magsq_avg: I^2+Q^2 power of complex AXI-Stream samples, scaled, saturated and optionally averaged.
// Latency: 4 clk (S1 operands, S2 squares, S3 sum, output register); one window result per 2^log_avg beats.
// Backpressure: elastic per-stage valid/ready, 1 sample/clk when o_tready is held high; o_tdata/o_tlast hold while stalled.
//
// Ports: clk, reset (sync, active-high), clear (sync flush, same effect as reset),
//        log_avg (log2 window length, clamped to MAX_LOG_AVG), peak_mode (peak-hold select),
//        i_tdata {I,Q} / i_tlast / i_tvalid / i_tready (input stream),
//        o_tdata / o_tlast / o_tvalid / o_tready (output stream).
// Optional feature: define COMPLEX_TO_MAGSQ_AVG_PEAK_EN to build the peak-hold path (peak_mode);
// when it is undefined, peak_mode is ignored and no peak logic exists.
module complex_to_magsq_avg #(
    parameter int WIDTH       = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int DROP_LSB    = 0,
    parameter int MAX_LOG_AVG = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [$clog2(MAX_LOG_AVG+1)-1:0]   log_avg,
    input  logic                               peak_mode,
    input  logic [2*WIDTH-1:0]                 i_tdata,
    input  logic                               i_tlast,
    input  logic                               i_tvalid,
    output logic                               i_tready,
    output logic [OUT_WIDTH-1:0]               o_tdata,
    output logic                               o_tlast,
    output logic                               o_tvalid,
    input  logic                               o_tready
);

    localparam int LW    = $clog2(MAX_LOG_AVG+1);
    localparam int MW    = 2*WIDTH;
    localparam int ACC_W = MW + MAX_LOG_AVG;
    localparam int CNT_W = (MAX_LOG_AVG > 0) ? MAX_LOG_AVG : 1;
    localparam int EXT_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
    localparam logic [EXT_W-1:0] MAX_OUT = EXT_W'({OUT_WIDTH{1'b1}});

    // Pipeline state
    logic                    s1_vld_q, s1_last_q;
    logic signed [WIDTH-1:0] s1_i_q, s1_q_q;
    logic                    s2_vld_q, s2_last_q;
    logic [MW-1:0]           s2_ii_q, s2_qq_q;
    logic                    s3_vld_q, s3_last_q;
    logic [MW-1:0]           s3_msq_q;

    // Window state
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [LW-1:0]           lavg_q;

    // Output register
    logic [OUT_WIDTH-1:0]    out_dat_q;
    logic                    out_last_q, out_vld_q;

    logic                    out_rdy, s3_rdy, s3_take, s3_adv, s2_adv, s1_adv;
    logic                    win_open, win_close;
    logic [LW-1:0]           log_clamp, eff_l;
    logic [CNT_W-1:0]        win_end;
    logic [ACC_W-1:0]        msq_ext, acc_nxt, shifted;
    logic [EXT_W-1:0]        ext;
    logic [OUT_WIDTH-1:0]    out_sat;
    logic signed [MW-1:0]    i_ext, q_ext;
    int unsigned             shamt;

`ifdef COMPLEX_TO_MAGSQ_AVG_PEAK_EN
    logic                    peak_q, peak_eff;
`else
    logic                    unused_peak_mode;
    assign unused_peak_mode = peak_mode;
`endif

    assign out_rdy  = !out_vld_q || o_tready;
    assign win_open = (cnt_q == '0);

    // Window parameters are frozen at the first beat of a window; later beats use the latched copy.
    assign log_clamp = (log_avg > LW'(MAX_LOG_AVG)) ? LW'(MAX_LOG_AVG) : log_avg;
    assign eff_l     = win_open ? log_clamp : lavg_q;
    assign win_end   = CNT_W'((32'd1 << eff_l) - 32'd1);
    // With eff_l == 0 the window end is count 0, so every beat closes its own window.
    assign win_close = (cnt_q == win_end) || s3_last_q;

    // S3 only needs the output register when its beat closes a window.
    assign s3_rdy   = !win_close || out_rdy;
    assign s3_take  = s3_vld_q && s3_rdy;
    assign s3_adv   = !s3_vld_q || s3_rdy;
    assign s2_adv   = !s2_vld_q || s3_adv;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign i_tready = s1_adv;

    // Sign-extend before squaring; the low MW bits of the MW x MW product are the exact square.
    assign i_ext = {{WIDTH{s1_i_q[WIDTH-1]}}, s1_i_q};
    assign q_ext = {{WIDTH{s1_q_q[WIDTH-1]}}, s1_q_q};

    assign msq_ext = ACC_W'(s3_msq_q);

    always_comb begin
        acc_nxt = acc_q + msq_ext;
        shamt   = 32'(eff_l) + DROP_LSB;
`ifdef COMPLEX_TO_MAGSQ_AVG_PEAK_EN
        peak_eff = win_open ? peak_mode : peak_q;
        if (peak_eff) begin
            // acc_q is zero at window open, so the max starts from the first beat.
            acc_nxt = (msq_ext > acc_q) ? msq_ext : acc_q;
            shamt   = DROP_LSB;
        end
`endif
        shifted = acc_nxt >> shamt;
        ext     = EXT_W'(shifted);
        out_sat = (ext > MAX_OUT) ? {OUT_WIDTH{1'b1}} : ext[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_ii_q    <= '0;
            s2_qq_q    <= '0;
            s3_vld_q   <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_msq_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            lavg_q     <= '0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
`ifdef COMPLEX_TO_MAGSQ_AVG_PEAK_EN
            peak_q     <= 1'b0;
`endif
        end else begin
            if (s1_adv) begin
                s1_vld_q <= i_tvalid;
                if (i_tvalid) begin
                    s1_i_q    <= i_tdata[2*WIDTH-1:WIDTH];
                    s1_q_q    <= i_tdata[WIDTH-1:0];
                    s1_last_q <= i_tlast;
                end
            end
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_ii_q   <= i_ext * i_ext;
                    s2_qq_q   <= q_ext * q_ext;
                    s2_last_q <= s1_last_q;
                end
            end
            if (s3_adv) begin
                s3_vld_q <= s2_vld_q;
                if (s2_vld_q) begin
                    s3_msq_q  <= s2_ii_q + s2_qq_q;
                    s3_last_q <= s2_last_q;
                end
            end

            if (s3_take) begin
                if (win_open) begin
                    lavg_q <= log_clamp;
`ifdef COMPLEX_TO_MAGSQ_AVG_PEAK_EN
                    peak_q <= peak_mode;
`endif
                end
                if (win_close) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            if (s3_take && win_close) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= out_sat;
                out_last_q <= s3_last_q;
            end else if (o_tready) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign o_tdata  = out_dat_q;
    assign o_tlast  = out_last_q;
    assign o_tvalid = out_vld_q;

endmodule

// File: tb/tb_complex_to_magsq_avg.sv
module tb_complex_to_magsq_avg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, peak_mode;
    logic [3:0]  log_avg;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;

    // Narrow-output instance for the saturation case
    logic        i16_tready;
    logic [15:0] o16_tdata;
    logic        o16_tlast, o16_tvalid;
    logic        o16_tready;

    complex_to_magsq_avg #(.WIDTH(16), .OUT_WIDTH(32), .DROP_LSB(0), .MAX_LOG_AVG(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .log_avg(log_avg), .peak_mode(peak_mode),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    complex_to_magsq_avg #(.WIDTH(16), .OUT_WIDTH(16), .DROP_LSB(0), .MAX_LOG_AVG(8)) dut16 (
        .clk(clk), .reset(reset), .clear(clear), .log_avg(log_avg), .peak_mode(peak_mode),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i16_tready),
        .o_tdata(o16_tdata), .o_tlast(o16_tlast), .o_tvalid(o16_tvalid), .o_tready(o16_tready)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] oq_dat[$];
    logic        oq_last[$];
    logic [31:0] exp_dat[$];
    logic        exp_last[$];
    logic        in_fire;
    logic [15:0] o16_seen;
    logic        stall_prev = 1'b0;
    logic [31:0] dat_prev;
    logic        last_prev;
    int          si[300];
    int          sq[300];
    bit          sl[300];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        in_fire = i_tvalid && i_tready;
        if (stall_prev) begin
            check("hold_dat", o_tdata, dat_prev);
            check("hold_last", o_tlast, last_prev);
        end
        stall_prev = o_tvalid && !o_tready;
        dat_prev   = o_tdata;
        last_prev  = o_tlast;
        if (o_tvalid && o_tready) begin
            oq_dat.push_back(o_tdata);
            oq_last.push_back(o_tlast);
        end
        if (o16_tvalid) o16_seen = o16_tdata;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < n + 100) begin
            i_tvalid = 1'b1;
            i_tdata  = {16'(si[idx]), 16'(sq[idx])};
            i_tlast  = sl[idx];
            cycle();
            if (in_fire) idx++;
            guard++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        check("send_done", idx, n);
    endtask

    task automatic beat(input int k, input int i, input int q, input bit l);
        si[k] = i;
        sq[k] = q;
        sl[k] = l;
    endtask

    task automatic drain();
        repeat (8) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; peak_mode = 1'b0; log_avg = 4'd0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        o_tready = 1'b1; o16_tready = 1'b1; o16_seen = '0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset state
        check("rst_vld", o_tvalid, 1'b0);
        check("rst_dat", o_tdata, 32'h0);
        check("rst_last", o_tlast, 1'b0);
        check("rst_rdy", i_tready, 1'b1);

        // Latency: presented after edge n, visible after edge n+4
        i_tvalid = 1'b1; i_tdata = {16'sd3, 16'sd4}; i_tlast = 1'b1;
        cycle();
        check("lat_accept", in_fire, 1'b1);
        i_tvalid = 1'b0; i_tlast = 1'b0;
        cycle();
        check("lat_vld_e2", o_tvalid, 1'b0);
        cycle();
        check("lat_vld_e3", o_tvalid, 1'b0);
        cycle();
        check("lat_vld_e4", o_tvalid, 1'b1);
        check("lat_dat", o_tdata, 32'd25);
        check("lat_last", o_tlast, 1'b1);
        cycle();
        check("lat_count", oq_dat.size(), 1);
        oq_dat.delete(); oq_last.delete();

        // Continuous 100-beat stream with no bubbles: beat j = (j, 1) -> j*j+1
        for (int c = 0; c < 104; c++) begin
            if (c < 100) begin
                i_tvalid = 1'b1;
                i_tdata  = {16'(c), 16'sd1};
                check("stream_rdy", i_tready, 1'b1);
            end else begin
                i_tvalid = 1'b0;
            end
            cycle();
            if (c >= 3 && c <= 102) begin
                check("stream_vld", o_tvalid, 1'b1);
                check("stream_dat", o_tdata, 32'((c-3)*(c-3) + 1));
            end
        end
        check("stream_count", oq_dat.size(), 100);
        oq_dat.delete(); oq_last.delete();

        // Most negative components: 2 * 2^30
        beat(0, -32768, -32768, 1'b0);
        send(1); drain();
        check("neg_count", oq_dat.size(), 1);
        check("neg_dat", oq_dat[0], 32'h8000_0000);
        oq_dat.delete(); oq_last.delete();

        // 256^2 + 256^2 = 0x20000: fits 32 bits, saturates 16 bits
        o16_seen = '0;
        beat(0, 256, 256, 1'b0);
        send(1); drain();
        check("sat16_dat", o16_seen, 16'hFFFF);
        check("sat32_dat", oq_dat[0], 32'h0002_0000);
        oq_dat.delete(); oq_last.delete();

        // log_avg=2: 10,20,29,41 -> 25; 8,8,8,8 (tlast on 4th) -> 8
        log_avg = 4'd2;
        beat(0, 1, 3, 1'b0); beat(1, 2, 4, 1'b0); beat(2, 2, 5, 1'b0); beat(3, 4, 5, 1'b0);
        beat(4, 2, 2, 1'b0); beat(5, 2, 2, 1'b0); beat(6, 2, 2, 1'b0); beat(7, 2, 2, 1'b1);
        send(8); drain();
        check("avg_count", oq_dat.size(), 2);
        check("avg0_dat", oq_dat[0], 32'd25);
        check("avg0_last", oq_last[0], 1'b0);
        check("avg1_dat", oq_dat[1], 32'd8);
        check("avg1_last", oq_last[1], 1'b1);
        oq_dat.delete(); oq_last.delete();

        // Truncated window 100,200 -> 300/4 = 75, then a fresh window of 4s -> 4
        beat(0, 6, 8, 1'b0); beat(1, 10, 10, 1'b1);
        for (int k = 2; k < 6; k++) beat(k, 0, 2, 1'b0);
        send(6); drain();
        check("trunc_count", oq_dat.size(), 2);
        check("trunc_dat", oq_dat[0], 32'd75);
        check("trunc_last", oq_last[0], 1'b1);
        check("fresh_dat", oq_dat[1], 32'd4);
        check("fresh_last", oq_last[1], 1'b0);
        oq_dat.delete(); oq_last.delete();

        // peak_mode: 5,90,8,13 (7 and 12 are not sums of two integer squares, so 8 and 13 stand in)
        peak_mode = 1'b1;
        beat(0, 1, 2, 1'b0); beat(1, 9, 3, 1'b0); beat(2, 2, 2, 1'b0); beat(3, 2, 3, 1'b0);
        send(4); drain();
        peak_mode = 1'b0;
        check("peak_count", oq_dat.size(), 1);
`ifdef COMPLEX_TO_MAGSQ_AVG_PEAK_EN
        check("peak_dat", oq_dat[0], 32'd90);
`else
        check("peak_dat", oq_dat[0], 32'd29);
`endif
        oq_dat.delete(); oq_last.delete();

        // log_avg=15 clamps to 8: 256 beats of 2 -> one output of 2
        log_avg = 4'd15;
        for (int k = 0; k < 256; k++) beat(k, 1, 1, 1'b0);
        send(256); drain();
        check("clamp_count", oq_dat.size(), 1);
        check("clamp_dat", oq_dat[0], 32'd2);
        oq_dat.delete(); oq_last.delete();

        // clear mid-window discards the partial sum
        log_avg = 4'd2;
        beat(0, 6, 8, 1'b0); beat(1, 10, 10, 1'b0);
        send(2); drain();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clr_vld", o_tvalid, 1'b0);
        for (int k = 0; k < 4; k++) beat(k, 0, 2, 1'b0);
        send(4); drain();
        check("clr_count", oq_dat.size(), 1);
        check("clr_dat", oq_dat[0], 32'd4);
        oq_dat.delete(); oq_last.delete();

        // Random stream, 30% output ready, log_avg=0
        log_avg = 4'd0;
        begin
            int sent = 0;
            int guard = 0;
            int ri, rq;
            bit rl;
            while (sent < 1000 && guard < 20000) begin
                o_tready = ($urandom_range(0, 9) < 3);
                if (!i_tvalid && $urandom_range(0, 3) != 0) begin
                    ri = int'($urandom_range(0, 65535)) - 32768;
                    rq = int'($urandom_range(0, 65535)) - 32768;
                    rl = 1'($urandom_range(0, 1));
                    i_tvalid = 1'b1;
                    i_tdata  = {16'(ri), 16'(rq)};
                    i_tlast  = rl;
                end
                cycle();
                if (in_fire) begin
                    exp_dat.push_back(32'(longint'(ri) * ri + longint'(rq) * rq));
                    exp_last.push_back(rl);
                    sent++;
                    i_tvalid = 1'b0;
                    i_tlast  = 1'b0;
                end
                guard++;
            end
            guard = 0;
            while (oq_dat.size() < 1000 && guard < 5000) begin
                o_tready = ($urandom_range(0, 9) < 3);
                cycle();
                guard++;
            end
            o_tready = 1'b1;
            drain();
            check("rand_sent", sent, 1000);
            check("rand_count", oq_dat.size(), exp_dat.size());
            for (int k = 0; k < 1000; k++) begin
                if (k < oq_dat.size() && k < exp_dat.size()) begin
                    check("rand_dat", oq_dat[k], exp_dat[k]);
                    check("rand_last", oq_last[k], exp_last[k]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
